mem_port_arbiter: RTL and testbench

- Shares one single-ported, multi-cycle unified memory between the pipeline's instruction-fetch port and its data-access port.
- Sits between the five-stage pipeline and the memory/cache. It serialises accesses, handshakes each requester and bounds data-side starvation of fetch.
- A memory watchdog converts a hung access into a completed access with an error flag.
- Requesters stall while their Req is high and Ready has not yet arrived.

---
 rtl/mem_port_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one multi-cycle memory port between instruction fetch and data access.
// Data wins ties up to MAX_DSTREAK consecutive grants; a watchdog completes hung accesses with Err set.
module mem_port_arbiter #(
    parameter int MAX_DSTREAK = 4,
    parameter int TIMEOUT_W   = 8
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        IReq,
    input  logic [31:0] IAddr,
    output logic [31:0] IRdata,
    output logic        IReady,
    input  logic        DReq,
    input  logic        DWe,
    input  logic [31:0] DAddr,
    input  logic [31:0] DWdata,
    output logic [31:0] DRdata,
    output logic        DReady,
    output logic        MemReq,
    output logic        MemWe,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWdata,
    input  logic [31:0] MemRdata,
    input  logic        MemReady,
    output logic        Err
);

    localparam int                   STREAK_W   = 4;
    localparam logic [STREAK_W-1:0]  STREAK_MAX = STREAK_W'(MAX_DSTREAK);
    localparam logic [TIMEOUT_W-1:0] WDOG_ALL   = '1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D,
        RESP
    } state_e;

    state_e               state_q, state_d;
    logic [STREAK_W-1:0]  streak_q, streak_d;
    logic [TIMEOUT_W-1:0] wdog_q, wdog_d;
    logic [TIMEOUT_W-1:0] wdog_inc;
    logic                 mem_req_q, mem_req_d;
    logic                 mem_we_q, mem_we_d;
    logic [31:0]          mem_addr_q, mem_addr_d;
    logic [31:0]          mem_wdata_q, mem_wdata_d;
    logic [31:0]          irdata_q, irdata_d;
    logic [31:0]          drdata_q, drdata_d;
    logic                 iready_q, iready_d;
    logic                 dready_q, dready_d;
    logic                 err_q, err_d;
    logic                 grant_d;
    logic                 finish;

    // NOTE: every variable gets its default before the case statement, so no path
    // through this block can leave a value unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        wdog_d      = wdog_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        irdata_d    = irdata_q;
        drdata_d    = drdata_q;
        iready_d    = 1'b0;
        dready_d    = 1'b0;
        err_d       = err_q;
        grant_d     = DReq && (!IReq || (streak_q < STREAK_MAX));
        // The watchdog value counting the current BUSY cycle; all-ones means
        // this is the (2^TIMEOUT_W-1)th cycle without MemReady.
        wdog_inc    = wdog_q + TIMEOUT_W'(1);
        finish      = MemReady || (wdog_inc == WDOG_ALL);

        unique case (state_q)
            IDLE: begin
                if (grant_d) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = DWe;
                    mem_addr_d  = DAddr;
                    mem_wdata_d = DWdata;
                    state_d     = BUSY_D;
                    if (!IReq) begin
                        streak_d = '0;
                    end else if (streak_q != STREAK_MAX) begin
                        streak_d = streak_q + STREAK_W'(1);
                    end
                end else if (IReq) begin
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = IAddr;
                    streak_d   = '0;
                    state_d    = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                wdog_d = wdog_inc;
                if (finish) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    wdog_d    = '0;
                    state_d   = RESP;
                    if (!MemReady) begin
                        err_d = 1'b1;
                    end
                    if (state_q == BUSY_I) begin
                        iready_d = 1'b1;
                        irdata_d = MemReady ? MemRdata : 32'h0;
                    end else begin
                        dready_d = 1'b1;
                        drdata_d = MemReady ? MemRdata : 32'h0;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q     <= IDLE;
            streak_q    <= '0;
            wdog_q      <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            irdata_q    <= '0;
            drdata_q    <= '0;
            iready_q    <= 1'b0;
            dready_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            wdog_q      <= wdog_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            irdata_q    <= irdata_d;
            drdata_q    <= drdata_d;
            iready_q    <= iready_d;
            dready_q    <= dready_d;
            err_q       <= err_d;
        end
    end

    assign MemReq   = mem_req_q;
    assign MemWe    = mem_we_q;
    assign MemAddr  = mem_addr_q;
    assign MemWdata = mem_wdata_q;
    assign IRdata   = irdata_q;
    assign IReady   = iready_q;
    assign DRdata   = drdata_q;
    assign DReady   = dready_q;
    assign Err      = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: per-scenario tasks plus a read-data scoreboard
// that pairs each Ready pulse with the value expected when the request was issued.
module tb_mem_port_arbiter;

    logic        CLK = 1'b0;
    logic        Reset = 1'b0;
    logic        IReq = 1'b0;
    logic [31:0] IAddr = '0;
    logic [31:0] IRdata;
    logic        IReady;
    logic        DReq = 1'b0;
    logic        DWe = 1'b0;
    logic [31:0] DAddr = '0;
    logic [31:0] DWdata = '0;
    logic [31:0] DRdata;
    logic        DReady;
    logic        MemReq;
    logic        MemWe;
    logic [31:0] MemAddr;
    logic [31:0] MemWdata;
    logic [31:0] MemRdata;
    logic        MemReady;
    logic        Err;

    // Memory model: zero-wait auto responder, or manual control from the tasks.
    logic        auto_mem = 1'b0;
    logic        man_ready = 1'b0;
    logic [31:0] man_rdata = '0;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] iq[$];
    logic [31:0] dq[$];
    logic [31:0] mon_exp;

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return {a[15:0], ~a[31:16]};
    endfunction

    assign MemReady = auto_mem ? MemReq : man_ready;
    assign MemRdata = auto_mem ? mem_f(MemAddr) : man_rdata;

    mem_port_arbiter #(
        .MAX_DSTREAK(4),
        .TIMEOUT_W  (8)
    ) dut (
        .CLK     (CLK),
        .Reset   (Reset),
        .IReq    (IReq),
        .IAddr   (IAddr),
        .IRdata  (IRdata),
        .IReady  (IReady),
        .DReq    (DReq),
        .DWe     (DWe),
        .DAddr   (DAddr),
        .DWdata  (DWdata),
        .DRdata  (DRdata),
        .DReady  (DReady),
        .MemReq  (MemReq),
        .MemWe   (MemWe),
        .MemAddr (MemAddr),
        .MemWdata(MemWdata),
        .MemRdata(MemRdata),
        .MemReady(MemReady),
        .Err     (Err)
    );

    // Scoreboard: every Ready pulse must match the oldest expected read data for that port.
    always @(negedge CLK) begin
        if (IReady) begin
            n_checks++;
            if (iq.size() == 0) begin
                n_fail++;
                $display("FAIL iready_unexpected: IReady=1 IRdata=%h, no fetch outstanding", IRdata);
            end else begin
                mon_exp = iq.pop_front();
                if (IRdata !== mon_exp) begin
                    n_fail++;
                    $display("FAIL irdata: got %h expected %h", IRdata, mon_exp);
                end
            end
        end
        if (DReady) begin
            n_checks++;
            if (dq.size() == 0) begin
                n_fail++;
                $display("FAIL dready_unexpected: DReady=1 DRdata=%h, no data access outstanding", DRdata);
            end else begin
                mon_exp = dq.pop_front();
                if (DRdata !== mon_exp) begin
                    n_fail++;
                    $display("FAIL drdata: got %h expected %h", DRdata, mon_exp);
                end
            end
        end
        if (IReady || DReady) begin
            n_checks++;
            if (IReady && DReady) begin
                n_fail++;
                $display("FAIL both_ready: IReady=%b DReady=%b expected at most one", IReady, DReady);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({MemReq, MemWe, IReady, DReady, Err} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: {MemReq,MemWe,IReady,DReady,Err}=%b expected 00000",
                     {MemReq, MemWe, IReady, DReady, Err});
        end
        n_checks++;
        if ({MemAddr, MemWdata, IRdata, DRdata} !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_data: MemAddr=%h MemWdata=%h IRdata=%h DRdata=%h expected all 0",
                     MemAddr, MemWdata, IRdata, DRdata);
        end
        Reset = 1'b1;
        tick();
    endtask

    task automatic test_fetch_read();
        auto_mem  = 1'b0;
        man_ready = 1'b0;
        man_rdata = 32'h8C010004;
        IAddr     = 32'h00400000;
        IReq      = 1'b1;
        iq.push_back(32'h8C010004);
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (c == 3) man_ready = 1'b1;
            n_checks++;
            if (MemReq !== 1'b1 || MemAddr !== 32'h00400000 || MemWe !== 1'b0) begin
                n_fail++;
                $display("FAIL fetch_busy c%0d: MemReq=%b MemAddr=%h MemWe=%b expected 1 00400000 0",
                         c, MemReq, MemAddr, MemWe);
            end
        end
        tick();
        man_ready = 1'b0;
        IReq      = 1'b0;
        n_checks++;
        if (IReady !== 1'b1 || DReady !== 1'b0 || MemReq !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_resp: IReady=%b DReady=%b MemReq=%b expected 1 0 0", IReady, DReady, MemReq);
        end
        tick();
        n_checks++;
        if (IReady !== 1'b0 || IRdata !== 32'h8C010004 || MemReq !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_hold: IReady=%b IRdata=%h MemReq=%b expected 0 8c010004 0",
                     IReady, IRdata, MemReq);
        end
    endtask

    task automatic test_data_write();
        man_rdata = 32'h0BADBEEF;
        DWe       = 1'b1;
        DAddr     = 32'h10010000;
        DWdata    = 32'hCAFEF00D;
        DReq      = 1'b1;
        dq.push_back(32'h0BADBEEF);
        tick();
        man_ready = 1'b1;
        n_checks++;
        if (MemReq !== 1'b1 || MemWe !== 1'b1 || MemAddr !== 32'h10010000 || MemWdata !== 32'hCAFEF00D) begin
            n_fail++;
            $display("FAIL write_issue: MemReq=%b MemWe=%b MemAddr=%h MemWdata=%h expected 1 1 10010000 cafef00d",
                     MemReq, MemWe, MemAddr, MemWdata);
        end
        tick();
        man_ready = 1'b0;
        DReq      = 1'b0;
        DWe       = 1'b0;
        n_checks++;
        if (DReady !== 1'b1 || MemReq !== 1'b0 || MemWe !== 1'b0) begin
            n_fail++;
            $display("FAIL write_resp: DReady=%b MemReq=%b MemWe=%b expected 1 0 0", DReady, MemReq, MemWe);
        end
        tick();
        tick();
        n_checks++;
        if (DReady !== 1'b0 || MemReq !== 1'b0) begin
            n_fail++;
            $display("FAIL write_idle: DReady=%b MemReq=%b expected 0 0", DReady, MemReq);
        end
    endtask

    task automatic test_simultaneous();
        auto_mem = 1'b1;
        IAddr    = 32'h00400010;
        DAddr    = 32'h10010020;
        DWe      = 1'b0;
        IReq     = 1'b1;
        DReq     = 1'b1;
        dq.push_back(mem_f(32'h10010020));
        iq.push_back(mem_f(32'h00400010));
        tick();
        n_checks++;
        if (MemReq !== 1'b1 || MemAddr !== 32'h10010020) begin
            n_fail++;
            $display("FAIL sim_data_first: MemReq=%b MemAddr=%h expected 1 10010020", MemReq, MemAddr);
        end
        tick();
        DReq = 1'b0;
        n_checks++;
        if (DReady !== 1'b1 || IReady !== 1'b0) begin
            n_fail++;
            $display("FAIL sim_dready: DReady=%b IReady=%b expected 1 0", DReady, IReady);
        end
        tick();
        n_checks++;
        if (MemReq !== 1'b0) begin
            n_fail++;
            $display("FAIL sim_idle: MemReq=%b expected 0", MemReq);
        end
        tick();
        n_checks++;
        if (MemReq !== 1'b1 || MemAddr !== 32'h00400010 || MemWe !== 1'b0) begin
            n_fail++;
            $display("FAIL sim_fetch_grant: MemReq=%b MemAddr=%h MemWe=%b expected 1 00400010 0",
                     MemReq, MemAddr, MemWe);
        end
        tick();
        IReq = 1'b0;
        n_checks++;
        if (IReady !== 1'b1) begin
            n_fail++;
            $display("FAIL sim_iready: IReady=%b expected 1", IReady);
        end
        tick();
        auto_mem = 1'b0;
    endtask

    // D bursts of four then a forced fetch, twice; the second burst proves the streak was cleared.
    task automatic test_starvation();
        logic [9:0] obs;
        logic [9:0] exp_seq;
        int         n_ev;
        int         n_d;
        int         n_i;
        obs      = '0;
        exp_seq  = 10'b10_0001_0000;
        n_ev     = 0;
        n_d      = 0;
        n_i      = 0;
        auto_mem = 1'b1;
        DWe      = 1'b0;
        DAddr    = 32'h10020000;
        IAddr    = 32'h00400100;
        dq.push_back(mem_f(32'h10020000));
        iq.push_back(mem_f(32'h00400100));
        DReq     = 1'b1;
        IReq     = 1'b1;
        for (int c = 0; c < 200 && n_ev < 10; c++) begin
            tick();
            if (DReady) begin
                n_ev++;
                n_d++;
                if (n_d < 8) begin
                    DAddr = 32'h10020000 + 32'(n_d * 4);
                    dq.push_back(mem_f(DAddr));
                end
            end
            if (IReady) begin
                obs[n_ev] = 1'b1;
                n_ev++;
                n_i++;
                if (n_i == 1) begin
                    IAddr = 32'h00400140;
                    iq.push_back(mem_f(IAddr));
                end else begin
                    IReq = 1'b0;
                    DReq = 1'b0;
                end
            end
        end
        n_checks++;
        if (n_ev != 10 || obs !== exp_seq) begin
            n_fail++;
            $display("FAIL starvation_order: events=%0d pattern=%b expected 10 events pattern=%b",
                     n_ev, obs, exp_seq);
        end
        IReq = 1'b0;
        DReq = 1'b0;
        tick();
        tick();
        auto_mem = 1'b0;
    endtask

    task automatic test_timeout();
        int busy;
        int n;
        busy      = 0;
        n         = 0;
        man_ready = 1'b0;
        IAddr     = 32'h00400200;
        IReq      = 1'b1;
        iq.push_back(32'h0);
        tick();
        while (IReady !== 1'b1 && n < 400) begin
            if (MemReq === 1'b1) busy++;
            tick();
            n++;
        end
        IReq = 1'b0;
        n_checks++;
        if (IReady !== 1'b1 || busy != 255) begin
            n_fail++;
            $display("FAIL timeout_latency: IReady=%b busy_cycles=%0d expected 1 255", IReady, busy);
        end
        n_checks++;
        if (Err !== 1'b1 || IRdata !== 32'h0) begin
            n_fail++;
            $display("FAIL timeout_err: Err=%b IRdata=%h expected 1 00000000", Err, IRdata);
        end
        tick();
        man_rdata = 32'h13579BDF;
        IAddr     = 32'h00400204;
        IReq      = 1'b1;
        iq.push_back(32'h13579BDF);
        tick();
        man_ready = 1'b1;
        tick();
        man_ready = 1'b0;
        IReq      = 1'b0;
        n_checks++;
        if (IReady !== 1'b1 || Err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_sticky: IReady=%b Err=%b expected 1 1", IReady, Err);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int n;
        n         = 0;
        auto_mem  = 1'b0;
        man_ready = 1'b0;
        DWe       = 1'b1;
        DAddr     = 32'h10030000;
        DWdata    = 32'h55AA55AA;
        DReq      = 1'b1;
        tick();
        tick();
        n_checks++;
        if (MemReq !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_busy: MemReq=%b expected 1", MemReq);
        end
        #2;
        Reset = 1'b0;
        #1;
        n_checks++;
        if ({MemReq, MemWe, IReady, DReady, Err} !== 5'b0 || {MemAddr, MemWdata} !== 64'h0) begin
            n_fail++;
            $display("FAIL midreset_async: MemReq=%b MemWe=%b IReady=%b DReady=%b Err=%b MemAddr=%h MemWdata=%h expected all 0",
                     MemReq, MemWe, IReady, DReady, Err, MemAddr, MemWdata);
        end
        DReq = 1'b0;
        DWe  = 1'b0;
        @(negedge CLK);
        tick();
        Reset    = 1'b1;
        tick();
        auto_mem = 1'b1;
        DAddr    = 32'h10030004;
        DReq     = 1'b1;
        dq.push_back(mem_f(32'h10030004));
        tick();
        while (DReady !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        DReq = 1'b0;
        n_checks++;
        if (DReady !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_recover: DReady=%b expected 1 within 20 cycles", DReady);
        end
        tick();
        tick();
        auto_mem = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fetch_read();
        test_data_write();
        test_simultaneous();
        test_starvation();
        test_timeout();
        test_reset_mid();
        n_checks++;
        if (iq.size() != 0 || dq.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: fetch left=%0d data left=%0d expected 0 0", iq.size(), dq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish within 100000 time units");
        $fatal(1);
    end

endmodule
